// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared core definitions for the ID/EX boundary: widths, ALU command codes
// and the packed control word carried from decode into execute.
package id_ex_pipe_reg_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned CMD_W      = 4;

    // ALU command encodings driven by the decoder into EXE
    typedef enum logic [CMD_W-1:0] {
        EXE_MOV = 4'b0001,
        EXE_MVN = 4'b1001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000
    } exe_cmd_e;

    // Decoded control word; the upper six bits are the ones that must be
    // zero whenever the slot holds a bubble.
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             b;
        logic             s;
        logic             imm;
        logic [CMD_W-1:0] exe_cmd;
    } id_ex_ctrl_t;

    localparam int unsigned CTRL_W    = $bits(id_ex_ctrl_t);
    localparam int unsigned QUAL_W    = 6;
    localparam int unsigned CTRL_DP_W = CTRL_W - QUAL_W;

endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// Generic pipeline field register: reset > freeze (hold) > clear (zero) > load.
module pipe_field_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next value: hold while frozen, otherwise zero or capture
    always_comb begin
        q_d = q_q;
        if (!freeze) begin
            q_d = clear ? '0 : d;
        end
    end

    // State register with synchronous reset that overrides freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded control, operands, immediates and
// PC, presenting them to EXE one cycle later with freeze, flush and bubble
// qualification.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CMD_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [CMD_W-1:0]      id_exe_cmd,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic                  id_carry,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic [CMD_W-1:0]      ex_exe_cmd,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic                  ex_imm,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_signed_imm_24,
    output logic                  ex_carry
);

    import id_ex_pipe_reg_pkg::*;

    localparam int unsigned WORD_CMD_W = $bits(id_ex_ctrl_t) - QUAL_W - 1;
    localparam int unsigned DP_W       = 3 * DATA_W + 3 * REG_ADDR_W + 12 + 24 + 1;

    id_ex_ctrl_t           ctrl_d;
    id_ex_ctrl_t           ctrl_q;
    logic [QUAL_W-1:0]     qual_q;
    logic [CTRL_DP_W-1:0]  ctrl_dp_q;
    logic                  qual_clear;
    logic [DP_W-1:0]       dp_d;
    logic [DP_W-1:0]       dp_q;

    // Pack the decoded control bits into the shared control word
    always_comb begin
        ctrl_d          = '0;
        ctrl_d.valid    = id_valid;
        ctrl_d.wb_en    = id_wb_en;
        ctrl_d.mem_r_en = id_mem_r_en;
        ctrl_d.mem_w_en = id_mem_w_en;
        ctrl_d.b        = id_b;
        ctrl_d.s        = id_s;
        ctrl_d.imm      = id_imm;
        ctrl_d.exe_cmd  = WORD_CMD_W'(id_exe_cmd);
    end

    // Side-effect bits are killed both by a flush and by a hazard bubble
    assign qual_clear = flush | ~id_valid;

    pipe_field_reg #(.WIDTH(QUAL_W)) u_ctrl_qual (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .clear  (qual_clear),
        .d      (ctrl_d[CTRL_W-1 -: QUAL_W]),
        .q      (qual_q)
    );

    // imm and exe_cmd behave as datapath: zeroed on flush only
    pipe_field_reg #(.WIDTH(CTRL_DP_W)) u_ctrl_dp (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .clear  (flush),
        .d      (ctrl_d[CTRL_DP_W-1:0]),
        .q      (ctrl_dp_q)
    );

    assign dp_d = {id_pc, id_val_rn, id_val_rm, id_dest, id_src1, id_src2,
                   id_shift_operand, id_signed_imm_24, id_carry};

    pipe_field_reg #(.WIDTH(DP_W)) u_data (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .clear  (flush),
        .d      (dp_d),
        .q      (dp_q)
    );

    assign ctrl_q = {qual_q, ctrl_dp_q};

    assign ex_valid    = ctrl_q.valid;
    assign ex_wb_en    = ctrl_q.wb_en;
    assign ex_mem_r_en = ctrl_q.mem_r_en;
    assign ex_mem_w_en = ctrl_q.mem_w_en;
    assign ex_b        = ctrl_q.b;
    assign ex_s        = ctrl_q.s;
    assign ex_imm      = ctrl_q.imm;
    assign ex_exe_cmd  = CMD_W'(ctrl_q.exe_cmd);

    assign {ex_pc, ex_val_rn, ex_val_rm, ex_dest, ex_src1, ex_src2,
            ex_shift_operand, ex_signed_imm_24, ex_carry} = dp_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for the ID/EX pipeline register: directed scenarios plus randomized
// traffic compared against a snapshot-level reference model.
module tb_id_ex_pipe_reg;

    typedef struct {
        logic        valid, wb_en, mem_r, mem_w, b, s, imm, carry;
        logic [31:0] pc, rn, rm;
        logic [3:0]  dest, src1, src2, cmd;
        logic [11:0] sh;
        logic [23:0] si;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, id_valid;
    logic [31:0] id_pc, rn_drv, id_val_rm;
    wire  [31:0] id_val_rn;
    logic [3:0]  id_dest, id_src1, id_src2, id_exe_cmd;
    logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_carry;
    logic [11:0] id_shift_operand;
    logic [23:0] id_signed_imm_24;

    logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_carry;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [3:0]  ex_dest, ex_src1, ex_src2, ex_exe_cmd;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;

    // Register file written on the falling edge, read combinationally by ID
    logic [31:0] rf [16];
    logic        use_rf, wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    int    n_checks = 0;
    int    n_errors = 0;
    snap_t exp_s;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    assign id_val_rn = use_rf ? rf[id_src1] : rn_drv;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
        .id_exe_cmd(id_exe_cmd), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_carry(id_carry),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_exe_cmd(ex_exe_cmd), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
        .ex_carry(ex_carry)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic snap_t zero_snap();
        snap_t z;
        z.valid = 0; z.wb_en = 0; z.mem_r = 0; z.mem_w = 0; z.b = 0; z.s = 0;
        z.imm = 0; z.carry = 0; z.pc = 0; z.rn = 0; z.rm = 0; z.dest = 0;
        z.src1 = 0; z.src2 = 0; z.cmd = 0; z.sh = 0; z.si = 0;
        return z;
    endfunction

    function automatic snap_t sample_in();
        snap_t v;
        v.valid = id_valid; v.wb_en = id_wb_en; v.mem_r = id_mem_r_en;
        v.mem_w = id_mem_w_en; v.b = id_b; v.s = id_s; v.imm = id_imm;
        v.carry = id_carry; v.pc = id_pc; v.rn = id_val_rn; v.rm = id_val_rm;
        v.dest = id_dest; v.src1 = id_src1; v.src2 = id_src2; v.cmd = id_exe_cmd;
        v.sh = id_shift_operand; v.si = id_signed_imm_24;
        return v;
    endfunction

    // What EXE should see after the next edge, from the priority rules alone
    function automatic snap_t model_next(snap_t cur, snap_t in, logic r, logic fz, logic fl);
        snap_t n;
        if (r)       n = zero_snap();
        else if (fz) n = cur;
        else if (fl) n = zero_snap();
        else begin
            n = in;
            if (!in.valid) begin
                n.wb_en = 0; n.mem_r = 0; n.mem_w = 0; n.b = 0; n.s = 0;
            end
        end
        return n;
    endfunction

    task automatic check_all();
        check_val("valid",  32'(ex_valid),    32'(exp_s.valid));
        check_val("wb_en",  32'(ex_wb_en),    32'(exp_s.wb_en));
        check_val("mem_r",  32'(ex_mem_r_en), 32'(exp_s.mem_r));
        check_val("mem_w",  32'(ex_mem_w_en), 32'(exp_s.mem_w));
        check_val("b",      32'(ex_b),        32'(exp_s.b));
        check_val("s",      32'(ex_s),        32'(exp_s.s));
        check_val("imm",    32'(ex_imm),      32'(exp_s.imm));
        check_val("carry",  32'(ex_carry),    32'(exp_s.carry));
        check_val("pc",     ex_pc,            exp_s.pc);
        check_val("val_rn", ex_val_rn,        exp_s.rn);
        check_val("val_rm", ex_val_rm,        exp_s.rm);
        check_val("dest",   32'(ex_dest),     32'(exp_s.dest));
        check_val("src1",   32'(ex_src1),     32'(exp_s.src1));
        check_val("src2",   32'(ex_src2),     32'(exp_s.src2));
        check_val("cmd",    32'(ex_exe_cmd),  32'(exp_s.cmd));
        check_val("shop",   32'(ex_shift_operand), 32'(exp_s.sh));
        check_val("imm24",  32'(ex_signed_imm_24), 32'(exp_s.si));
    endtask

    // One clock: snapshot inputs after the falling edge, advance the model,
    // then compare every output just after the rising edge
    task automatic step();
        snap_t nxt;
        @(negedge clk); #1;
        nxt = model_next(exp_s, sample_in(), rst, freeze, flush);
        @(posedge clk); #1;
        exp_s = nxt;
        check_all();
    endtask

    task automatic set_nop();
        rst = 0; freeze = 0; flush = 0; id_valid = 1; use_rf = 0; wb_we = 0;
        wb_addr = 0; wb_data = 0;
        id_pc = 0; rn_drv = 0; id_val_rm = 0; id_dest = 0; id_src1 = 0; id_src2 = 0;
        id_exe_cmd = 0; id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0; id_b = 0;
        id_s = 0; id_imm = 0; id_carry = 0; id_shift_operand = 0; id_signed_imm_24 = 0;
    endtask

    task automatic randomize_inputs();
        rst      = ($urandom_range(0, 31) == 0);
        freeze   = ($urandom_range(0, 4) == 0);
        flush    = ($urandom_range(0, 5) == 0);
        id_valid = ($urandom_range(0, 3) != 0);
        id_pc = $urandom; rn_drv = $urandom; id_val_rm = $urandom;
        id_dest = 4'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
        id_exe_cmd = 4'($urandom);
        id_wb_en = 1'($urandom); id_mem_r_en = 1'($urandom); id_mem_w_en = 1'($urandom);
        id_b = 1'($urandom); id_s = 1'($urandom); id_imm = 1'($urandom);
        id_carry = 1'($urandom);
        id_shift_operand = 12'($urandom); id_signed_imm_24 = 24'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        set_nop();
        exp_s = zero_snap();

        // Reset with every ID input driven high
        rst = 1; id_valid = 1; id_pc = '1; rn_drv = '1; id_val_rm = '1; id_dest = '1;
        id_src1 = '1; id_src2 = '1; id_exe_cmd = '1; id_wb_en = 1; id_mem_r_en = 1;
        id_mem_w_en = 1; id_b = 1; id_s = 1; id_imm = 1; id_carry = 1;
        id_shift_operand = '1; id_signed_imm_24 = '1;
        step(); step();
        check_val("rst_valid", 32'(ex_valid), 32'h0);
        check_val("rst_pc", ex_pc, 32'h0);

        // First load after reset
        set_nop(); id_pc = 32'h8;
        step();
        check_val("first_pc", ex_pc, 32'h8);
        check_val("first_valid", 32'(ex_valid), 32'h1);

        // Load with ADD; outputs must not move before the edge
        set_nop(); rn_drv = 32'hA; id_val_rm = 32'hFFFF_FFF6; id_exe_cmd = 4'b0010;
        id_wb_en = 1; id_dest = 4'd3;
        #1;
        check_val("pre_edge_rn", ex_val_rn, 32'h8 - 32'h8);
        check_val("pre_edge_cmd", 32'(ex_exe_cmd), 32'h0);
        step();
        check_val("load_rn", ex_val_rn, 32'hA);
        check_val("load_rm", ex_val_rm, 32'hFFFF_FFF6);
        check_val("load_cmd", 32'(ex_exe_cmd), 32'h2);
        check_val("load_wb", 32'(ex_wb_en), 32'h1);
        check_val("load_dest", 32'(ex_dest), 32'h3);

        // Freeze dominates flush; flush re-sampled once freeze drops
        set_nop(); id_dest = 4'd5; id_wb_en = 1;
        step();
        freeze = 1; flush = 1; id_dest = 4'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("frz_dest", 32'(ex_dest), 32'h5);
            check_val("frz_valid", 32'(ex_valid), 32'h1);
        end
        freeze = 0;
        step();
        check_val("unfrz_valid", 32'(ex_valid), 32'h0);
        check_val("unfrz_wb", 32'(ex_wb_en), 32'h0);

        // Flush of a real store/branch instruction
        set_nop(); flush = 1; id_mem_w_en = 1; id_b = 1; rn_drv = 32'h1234_5678;
        step();
        check_val("fl_memw", 32'(ex_mem_w_en), 32'h0);
        check_val("fl_b", 32'(ex_b), 32'h0);
        check_val("fl_rn", ex_val_rn, 32'h0);
        check_val("fl_valid", 32'(ex_valid), 32'h0);

        // Back-to-back flushes keep producing bubbles
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h100 + 32'(i * 4);
            step();
            check_val("fl2_valid", 32'(ex_valid), 32'h0);
        end

        // Hazard bubble: control masked, datapath captured
        set_nop(); id_valid = 0; id_wb_en = 1; id_s = 1; id_val_rm = 32'h55;
        step();
        check_val("hz_wb", 32'(ex_wb_en), 32'h0);
        check_val("hz_s", 32'(ex_s), 32'h0);
        check_val("hz_valid", 32'(ex_valid), 32'h0);
        check_val("hz_rm", ex_val_rm, 32'h55);

        // Reset while frozen, then stay frozen on cleared state
        set_nop(); id_wb_en = 1; id_pc = 32'h44; step();
        freeze = 1; rst = 1; step();
        check_val("rstfrz_pc", ex_pc, 32'h0);
        rst = 0; step();
        check_val("rstfrz_hold_valid", 32'(ex_valid), 32'h0);
        check_val("rstfrz_hold_pc", ex_pc, 32'h0);

        // Write-back on the falling edge is visible to the ID read that cycle
        set_nop(); use_rf = 1; id_src1 = 4'd4;
        wb_we = 1; wb_addr = 4'd4; wb_data = 32'hCAFE_F00D;
        step();
        check_val("wtr_rn", ex_val_rn, 32'hCAFE_F00D);
        set_nop();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the ARM-subset five-stage core. It captures the decoded control word, the two operand values read from the register file (reg1/reg2), the immediate fields and the PC. It presents them to the EXE stage one cycle later.
- Supports freeze (memory stall), flush (taken branch) and a valid bit, so EXE and hazard logic can tell real instructions from bubbles.
- Register-file writes happen on the falling edge and this block samples on the rising edge, so a write-back in cycle N is visible to an ID read captured at the end of cycle N.

Parameters:
- DATA_W, 32, width of PC, operand values and status word paths
- REG_ADDR_W, 4, register index width (R0-R14 plus R15/PC encoding)
- CMD_W, 4, EXE_CMD width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  hold all state (memory stall)
- flush  in  1  replace incoming instruction with a bubble (taken branch)
- id_valid  in  1  ID stage holds a real instruction (0 = hazard bubble inserted by hazard unit)
- id_pc  in  DATA_W  PC+4 of ID instruction
- id_val_rn  in  DATA_W  register file reg1
- id_val_rm  in  DATA_W  register file reg2
- id_dest  in  REG_ADDR_W  destination register
- id_src1, id_src2  in  REG_ADDR_W  source indices (for forwarding)
- id_exe_cmd  in  CMD_W  ALU command
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  control bits
- id_shift_operand  in  12  shifter operand field
- id_signed_imm_24  in  24  branch offset
- id_carry  in  1  C flag from status register at ID time
- ex_*  out  same widths  registered copies of every id_* input above (ex_valid, ex_pc, ex_val_rn, ...)

Behaviour:
- Update priority on each rising clk: rst > freeze > flush > load.
- rst=1: every ex_* output is 0, including ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b and ex_s. Reset is honoured even while freeze=1.
- freeze=1 (rst=0): all ex_* hold their values; flush is ignored that cycle. The branch raising flush stays in EXE, so flush is re-sampled when freeze drops.
- flush=1, freeze=0: register a bubble.
  - ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b and ex_s become 0.
  - Datapath fields (pc, val_rn, val_rm, dest, src1, src2, exe_cmd, imm fields, carry) become 0 as well, for deterministic waveforms.
- Normal load: all ex_* take their id_* values.
  - Qualification: if id_valid=0, the same control bits as a flush are forced to 0 and ex_valid=0. Datapath fields still load unmasked.
  - Invariant: ex_valid=0 implies ex_wb_en = ex_mem_r_en = ex_mem_w_en = ex_b = ex_s = 0.
- Latency: exactly one clock from id_* to ex_*. There is no combinational path from any input to any output.
- Width rules: straight capture, no sign extension. Sign extension of signed_imm_24 happens in EXE.
- Reset mid-stall: rst during freeze clears state. Freeze remaining high afterwards holds the cleared state.
- Back-to-back flushes: each produces a bubble, and ex_valid stays 0 throughout.

Decomposition:
- Shared core package holds:
  - CMD_W, REG_ADDR_W, DATA_W constants
  - EXE_CMD encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR)
  - a packed id_ex control typedef {valid, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd}
- One sub-module, pipe_field_reg (parameterised width, ports clk/rst/freeze/clear/d/q), instantiated per field group.
  - Control group: clear = flush | ~id_valid.
  - Datapath group: clear = flush.

Test Plan:
- Reset: rst=1 for 2 cycles with id_* all-ones -> every ex_* = 0; release rst, id_valid=1, id_pc=0x00000008 -> ex_pc=0x00000008 and ex_valid=1 after one edge.
- Load: id_val_rn=0x0000000A, id_val_rm=0xFFFFFFF6, id_exe_cmd=ADD (4'b0010), id_wb_en=1, id_dest=4'd3 -> the same values on ex_* one cycle later, and not before the edge.
- Freeze: load dest=5, then freeze=1 for 3 cycles while id_dest=7 and flush=1 -> ex_dest stays 5, ex_valid stays 1; freeze=0 with flush=1 -> bubble with ex_valid=0 and ex_wb_en=0.
- Flush: flush=1 with id_valid=1, id_mem_w_en=1, id_b=1, id_val_rn=0x12345678 -> ex_mem_w_en=0, ex_b=0, ex_val_rn=0, ex_valid=0.
- Hazard bubble: id_valid=0, id_wb_en=1, id_s=1, id_val_rm=0x55 -> ex_wb_en=0, ex_s=0, ex_valid=0, ex_val_rm=0x55.
- Write-then-read: WB writes R4=0xCAFEF00D on the falling edge while ID reads src1=4 -> ex_val_rn=0xCAFEF00D after the next rising edge. This runs with the register file instantiated.
